// File: rtl/thread_issue_scheduler_if.sv
// ============================================================================
// thread_issue_scheduler_if : spawn / issue / retire / status bundle. Rev 1.0
// ============================================================================
`default_nettype none

interface thread_issue_scheduler_if #(
  parameter int THREADS    = 8,
  parameter int DATA_SLOTS = 8
);
  localparam int TID_W = $clog2(THREADS);
  localparam int DA_W  = $clog2(DATA_SLOTS);

  logic             spawn_valid;
  logic [TID_W-1:0] spawn_id;
  logic [DA_W-1:0]  spawn_data_addr;
  logic             issue_valid;
  logic             issue_ready;
  logic             issue_active;
  logic [TID_W-1:0] issue_id;
  logic [DA_W-1:0]  issue_data_addr;
  logic             retire_valid;
  logic [TID_W-1:0] retire_id;
  logic             retire_halt;
  logic             spawn_err;
  logic             retire_err;
  logic [TID_W:0]   inflight_cnt;
  logic             idle;
  logic [31:0]      issue_count;
  logic [31:0]      stall_count;

  modport master (
    output spawn_valid, spawn_id, spawn_data_addr, issue_ready,
           retire_valid, retire_id, retire_halt,
    input  issue_valid, issue_active, issue_id, issue_data_addr,
           spawn_err, retire_err, inflight_cnt, idle, issue_count, stall_count
  );

  modport slave (
    input  spawn_valid, spawn_id, spawn_data_addr, issue_ready,
           retire_valid, retire_id, retire_halt,
    output issue_valid, issue_active, issue_id, issue_data_addr,
           spawn_err, retire_err, inflight_cnt, idle, issue_count, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/thread_issue_scheduler.sv
// ============================================================================
// thread_issue_scheduler : round-robin thread issue scheduler (perf counters
// under THREAD_SCHED_PERF_EN). Rev 1.0
// ============================================================================
`default_nettype none

module thread_issue_scheduler #(
  parameter int THREADS    = 8,
  parameter int DATA_SLOTS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  thread_issue_scheduler_if.slave sched
);
  localparam int TID_W = $clog2(THREADS);
  localparam int DA_W  = $clog2(DATA_SLOTS);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_READY    = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;

  logic [1:0]       state      [THREADS];
  logic [1:0]       state_nx   [THREADS];
  logic [DA_W-1:0]  daddr      [THREADS];
  logic [DA_W-1:0]  daddr_nx   [THREADS];
  logic [TID_W-1:0] rr_ptr,    rr_ptr_nx;
  logic             slot_valid, slot_valid_nx;
  logic [TID_W-1:0] slot_id,   slot_id_nx;
  logic [DA_W-1:0]  slot_addr, slot_addr_nx;
  logic             spawn_err_q,  spawn_err_nx;
  logic             retire_err_q, retire_err_nx;
  logic [TID_W:0]   inflight_q,   inflight_nx;

  logic             found;
  logic [TID_W-1:0] idx;
  logic [TID_W-1:0] sel;
  logic             any_busy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < THREADS; t++) begin
        state[t] <= ST_IDLE;
        daddr[t] <= '0;
      end
      rr_ptr       <= TID_W'(THREADS - 1);
      slot_valid   <= 1'b0;
      slot_id      <= '0;
      slot_addr    <= '0;
      spawn_err_q  <= 1'b0;
      retire_err_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        state[t] <= state_nx[t];
        daddr[t] <= daddr_nx[t];
      end
      rr_ptr       <= rr_ptr_nx;
      slot_valid   <= slot_valid_nx;
      slot_id      <= slot_id_nx;
      slot_addr    <= slot_addr_nx;
      spawn_err_q  <= spawn_err_nx;
      retire_err_q <= retire_err_nx;
      inflight_q   <= inflight_nx;
    end
  end

  // Next-state: all decisions look at registered state only, so a spawn or
  // retire at this edge cannot be selected until the following one.
  always_comb begin
    state_nx      = state;
    daddr_nx      = daddr;
    rr_ptr_nx     = rr_ptr;
    slot_valid_nx = slot_valid;
    slot_id_nx    = slot_id;
    slot_addr_nx  = slot_addr;
    spawn_err_nx  = 1'b0;
    retire_err_nx = 1'b0;
    found         = 1'b0;
    idx           = '0;
    sel           = '0;
    inflight_nx   = '0;

    if (sched.retire_valid) begin
      if (state[sched.retire_id] == ST_INFLIGHT) begin
        state_nx[sched.retire_id] = sched.retire_halt ? ST_IDLE : ST_READY;
      end else begin
        retire_err_nx = 1'b1;
      end
    end

    if (sched.spawn_valid) begin
      if (state[sched.spawn_id] == ST_IDLE) begin
        state_nx[sched.spawn_id] = ST_READY;
        daddr_nx[sched.spawn_id] = sched.spawn_data_addr;
      end else begin
        spawn_err_nx = 1'b1;
      end
    end

    if (!slot_valid || sched.issue_ready) begin
      for (int k = 1; k <= THREADS; k++) begin
        idx = rr_ptr + TID_W'(k);
        if (!found && state[idx] == ST_READY) begin
          found = 1'b1;
          sel   = idx;
        end
      end
      slot_valid_nx = found;
      if (found) begin
        slot_id_nx    = sel;
        slot_addr_nx  = daddr[sel];
        state_nx[sel] = ST_INFLIGHT;
        rr_ptr_nx     = sel;
      end
    end

    for (int t = 0; t < THREADS; t++) begin
      if (state_nx[t] == ST_INFLIGHT) begin
        inflight_nx = inflight_nx + (TID_W+1)'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    any_busy = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      if (state[t] != ST_IDLE) begin
        any_busy = 1'b1;
      end
    end
    sched.issue_valid     = slot_valid;
    sched.issue_active    = slot_valid;
    sched.issue_id        = slot_id;
    sched.issue_data_addr = slot_addr;
    sched.spawn_err       = spawn_err_q;
    sched.retire_err      = retire_err_q;
    sched.inflight_cnt    = inflight_q;
    sched.idle            = !slot_valid && !any_busy;
  end

`ifdef THREAD_SCHED_PERF_EN
  logic [31:0] issue_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (slot_valid && sched.issue_ready && issue_count_q != 32'hFFFF_FFFF) begin
        issue_count_q <= issue_count_q + 32'd1;
      end
      if (slot_valid && !sched.issue_ready && stall_count_q != 32'hFFFF_FFFF) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign sched.issue_count = issue_count_q;
  assign sched.stall_count = stall_count_q;
`else
  assign sched.issue_count = 32'd0;
  assign sched.stall_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_thread_issue_scheduler.sv
// ============================================================================
// tb_thread_issue_scheduler : scoreboard bench for thread_issue_scheduler. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_thread_issue_scheduler;
  localparam int THREADS    = 8;
  localparam int DATA_SLOTS = 8;
  localparam int TID_W      = 3;
  localparam int DA_W       = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  thread_issue_scheduler_if #(.THREADS(THREADS), .DATA_SLOTS(DATA_SLOTS)) bus();

  thread_issue_scheduler #(.THREADS(THREADS), .DATA_SLOTS(DATA_SLOTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sched (bus)
  );

  typedef struct packed {
    logic [TID_W-1:0] id;
    logic [DA_W-1:0]  addr;
  } issue_t;

  issue_t exp_q[$];
  int     tests = 0;
  int     fails = 0;

  // Scoreboard: every accepted issue must match the head of the queue.
  always @(negedge clk) begin : sb
    issue_t e;
    if (rst_n && bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got id=%0d addr=%0d, required no issue",
                 bus.issue_id, bus.issue_data_addr);
      end else begin
        e = exp_q.pop_front();
        if (bus.issue_id !== e.id || bus.issue_data_addr !== e.addr) begin
          fails++;
          $display("FAIL issue_order: got id=%0d addr=%0d, required id=%0d addr=%0d",
                   bus.issue_id, bus.issue_data_addr, e.id, e.addr);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.spawn_valid     = 1'b0;
    bus.spawn_id        = '0;
    bus.spawn_data_addr = '0;
    bus.retire_valid    = 1'b0;
    bus.retire_id       = '0;
    bus.retire_halt     = 1'b0;
  endtask

  task automatic spawn(input int id, input int addr);
    bus.spawn_valid     = 1'b1;
    bus.spawn_id        = TID_W'(id);
    bus.spawn_data_addr = DA_W'(addr);
  endtask

  task automatic retire(input int id, input bit halt);
    bus.retire_valid = 1'b1;
    bus.retire_id    = TID_W'(id);
    bus.retire_halt  = halt;
  endtask

  task automatic push_exp(input int id, input int addr);
    issue_t e;
    e.id   = TID_W'(id);
    e.addr = DA_W'(addr);
    exp_q.push_back(e);
  endtask

  task automatic drain(output bit ok);
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.issue_ready = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.issue_ready = 1'b0;
    repeat (2) tick();
    tests++;
    if (bus.issue_valid !== 1'b0 || bus.issue_active !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %0b/%0b, required 0/0", bus.issue_valid, bus.issue_active);
    end
    tests++;
    if (bus.issue_id !== 3'd0 || bus.issue_data_addr !== 3'd0) begin
      fails++; $display("FAIL reset_slot: got id=%0d addr=%0d, required 0/0", bus.issue_id, bus.issue_data_addr);
    end
    tests++;
    if (bus.spawn_err !== 1'b0 || bus.retire_err !== 1'b0 || bus.inflight_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_status: got serr=%0b rerr=%0b cnt=%0d, required 0/0/0",
                        bus.spawn_err, bus.retire_err, bus.inflight_cnt);
    end
    tests++;
    if (bus.idle !== 1'b1 || bus.issue_count !== 32'd0 || bus.stall_count !== 32'd0) begin
      fails++; $display("FAIL reset_idle_counters: got idle=%0b ic=%0d sc=%0d, required 1/0/0",
                        bus.idle, bus.issue_count, bus.stall_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_issue();
    bit ok;
    spawn(0, 3);
    tick();
    clear_inputs();
    tests++;
    if (bus.issue_valid !== 1'b0 || bus.idle !== 1'b0) begin
      fails++; $display("FAIL first_latency: got valid=%0b idle=%0b, required 0/0", bus.issue_valid, bus.idle);
    end
    tick();
    tests++;
    if (bus.issue_valid !== 1'b1 || bus.issue_id !== 3'd0 || bus.issue_data_addr !== 3'd3) begin
      fails++; $display("FAIL first_issue: got valid=%0b id=%0d addr=%0d, required 1/0/3",
                        bus.issue_valid, bus.issue_id, bus.issue_data_addr);
    end
    tests++;
    if (bus.inflight_cnt !== 4'd1) begin
      fails++; $display("FAIL first_inflight: got %0d, required 1", bus.inflight_cnt);
    end
    push_exp(0, 3);
    bus.issue_ready = 1'b1;
    drain(ok);
    bus.issue_ready = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL first_drain: got %0d pending, required 0", exp_q.size()); end
    retire(0, 1'b1);
    tick();
    clear_inputs();
    tests++;
    if (bus.idle !== 1'b1 || bus.inflight_cnt !== 4'd0 || bus.retire_err !== 1'b0) begin
      fails++; $display("FAIL first_retire: got idle=%0b cnt=%0d rerr=%0b, required 1/0/0",
                        bus.idle, bus.inflight_cnt, bus.retire_err);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int ids[3] = '{1, 2, 5};
    int round3[3] = '{2, 1, 5};
    // Round 1: spawn 1,2,5 with ready held high.
    foreach (ids[i]) push_exp(ids[i], ids[i] + 1);
    bus.issue_ready = 1'b1;
    foreach (ids[i]) begin
      spawn(ids[i], ids[i] + 1);
      tick();
    end
    clear_inputs();
    drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rr1_drain: got %0d pending, required 0", exp_q.size()); end
    tests++;
    if (bus.inflight_cnt !== 4'd3 || bus.idle !== 1'b0) begin
      fails++; $display("FAIL rr1_state: got cnt=%0d idle=%0b, required 3/0", bus.inflight_cnt, bus.idle);
    end
    // Round 2: reschedule in the same order.
    foreach (ids[i]) push_exp(ids[i], ids[i] + 1);
    foreach (ids[i]) begin
      retire(ids[i], 1'b0);
      tick();
      tests++;
      if (bus.idle !== 1'b0 || bus.retire_err !== 1'b0) begin
        fails++; $display("FAIL rr2_idle: got idle=%0b rerr=%0b, required 0/0", bus.idle, bus.retire_err);
      end
    end
    clear_inputs();
    drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rr2_drain: got %0d pending, required 0", exp_q.size()); end
    // Round 3: thread 2 grabs the slot first, so the pointer passes 1 and 5 wins next.
    bus.issue_ready = 1'b0;
    foreach (round3[i]) begin
      retire(round3[i], 1'b0);
      tick();
    end
    clear_inputs();
    tick();
    push_exp(2, 3);
    push_exp(5, 6);
    push_exp(1, 2);
    bus.issue_ready = 1'b1;
    drain(ok);
    bus.issue_ready = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL rr3_drain: got %0d pending, required 0", exp_q.size()); end
    foreach (ids[i]) begin
      retire(ids[i], 1'b1);
      tick();
    end
    clear_inputs();
    tests++;
    if (bus.idle !== 1'b1 || bus.inflight_cnt !== 4'd0) begin
      fails++; $display("FAIL rr_cleanup: got idle=%0b cnt=%0d, required 1/0", bus.idle, bus.inflight_cnt);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    spawn(3, 6);
    tick();
    clear_inputs();
    tick();
    tests++;
    if (bus.issue_valid !== 1'b1) begin
      fails++; $display("FAIL stall_load: got valid=%0b, required 1", bus.issue_valid);
    end
    push_exp(3, 6);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (bus.issue_valid !== 1'b1 || bus.issue_id !== 3'd3 || bus.issue_data_addr !== 3'd6) begin
        fails++; $display("FAIL stall_hold: got valid=%0b id=%0d addr=%0d, required 1/3/6",
                          bus.issue_valid, bus.issue_id, bus.issue_data_addr);
      end
    end
`ifdef THREAD_SCHED_PERF_EN
    tests++;
    if (bus.stall_count !== 32'd4 || bus.issue_count !== 32'd0) begin
      fails++; $display("FAIL stall_count: got sc=%0d ic=%0d, required 4/0", bus.stall_count, bus.issue_count);
    end
`else
    tests++;
    if (bus.stall_count !== 32'd0 || bus.issue_count !== 32'd0) begin
      fails++; $display("FAIL stall_count_tied: got sc=%0d ic=%0d, required 0/0", bus.stall_count, bus.issue_count);
    end
`endif
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    tests++;
    if (bus.issue_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL stall_accept: got valid=%0b pending=%0d, required 0/0", bus.issue_valid, exp_q.size());
    end
`ifdef THREAD_SCHED_PERF_EN
    tests++;
    if (bus.issue_count !== 32'd1 || bus.stall_count !== 32'd4) begin
      fails++; $display("FAIL issue_count: got ic=%0d sc=%0d, required 1/4", bus.issue_count, bus.stall_count);
    end
`endif
    retire(3, 1'b1);
    tick();
    clear_inputs();
  endtask

  task automatic test_errors();
    bit ok;
    spawn(4, 1);
    tick();
    tests++;
    if (bus.spawn_err !== 1'b0) begin
      fails++; $display("FAIL err_first_spawn: got serr=%0b, required 0", bus.spawn_err);
    end
    spawn(4, 7);
    retire(6, 1'b0);
    tick();
    clear_inputs();
    tests++;
    if (bus.spawn_err !== 1'b1 || bus.retire_err !== 1'b1) begin
      fails++; $display("FAIL err_pulse: got serr=%0b rerr=%0b, required 1/1", bus.spawn_err, bus.retire_err);
    end
    tests++;
    if (bus.issue_valid !== 1'b1 || bus.issue_id !== 3'd4 || bus.issue_data_addr !== 3'd1 ||
        bus.inflight_cnt !== 4'd1) begin
      fails++; $display("FAIL err_no_change: got valid=%0b id=%0d addr=%0d cnt=%0d, required 1/4/1/1",
                        bus.issue_valid, bus.issue_id, bus.issue_data_addr, bus.inflight_cnt);
    end
    tick();
    tests++;
    if (bus.spawn_err !== 1'b0 || bus.retire_err !== 1'b0) begin
      fails++; $display("FAIL err_one_cycle: got serr=%0b rerr=%0b, required 0/0", bus.spawn_err, bus.retire_err);
    end
    push_exp(4, 1);
    bus.issue_ready = 1'b1;
    drain(ok);
    bus.issue_ready = 1'b0;
    retire(4, 1'b1);
    tick();
    clear_inputs();
    tests++;
    if (!ok || bus.idle !== 1'b1) begin
      fails++; $display("FAIL err_cleanup: got drained=%0b idle=%0b, required 1/1", ok, bus.idle);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    spawn(2, 5);
    tick();
    clear_inputs();
    tick();
    push_exp(2, 5);
    bus.issue_ready = 1'b1;
    drain(ok);
    bus.issue_ready = 1'b0;
    retire(2, 1'b1);
    spawn(2, 2);
    tick();
    clear_inputs();
    tests++;
    if (bus.spawn_err !== 1'b1 || bus.retire_err !== 1'b0) begin
      fails++; $display("FAIL same_errs: got serr=%0b rerr=%0b, required 1/0", bus.spawn_err, bus.retire_err);
    end
    tests++;
    if (bus.idle !== 1'b1 || bus.inflight_cnt !== 4'd0) begin
      fails++; $display("FAIL same_idle: got idle=%0b cnt=%0d, required 1/0", bus.idle, bus.inflight_cnt);
    end
    tick();
    spawn(2, 4);
    tick();
    clear_inputs();
    tests++;
    if (bus.spawn_err !== 1'b0 || bus.issue_valid !== 1'b0) begin
      fails++; $display("FAIL same_respawn: got serr=%0b valid=%0b, required 0/0", bus.spawn_err, bus.issue_valid);
    end
    tick();
    tests++;
    if (bus.issue_valid !== 1'b1 || bus.issue_id !== 3'd2 || bus.issue_data_addr !== 3'd4) begin
      fails++; $display("FAIL same_reissue: got valid=%0b id=%0d addr=%0d, required 1/2/4",
                        bus.issue_valid, bus.issue_id, bus.issue_data_addr);
    end
    push_exp(2, 4);
    bus.issue_ready = 1'b1;
    drain(ok);
    bus.issue_ready = 1'b0;
    retire(2, 1'b1);
    tick();
    clear_inputs();
    tests++;
    if (!ok || bus.idle !== 1'b1) begin
      fails++; $display("FAIL same_cleanup: got drained=%0b idle=%0b, required 1/1", ok, bus.idle);
    end
  endtask

  task automatic test_async_reset();
    bus.issue_ready = 1'b1;
    push_exp(0, 0);
    push_exp(1, 5);
    spawn(0, 0);
    tick();
    spawn(1, 5);
    tick();
    clear_inputs();
    repeat (2) tick();
    bus.issue_ready = 1'b0;
    spawn(2, 7);
    tick();
    clear_inputs();
    tick();
    tests++;
    if (bus.inflight_cnt !== 4'd3 || bus.issue_valid !== 1'b1 || bus.issue_id !== 3'd2) begin
      fails++; $display("FAIL areset_setup: got cnt=%0d valid=%0b id=%0d, required 3/1/2",
                        bus.inflight_cnt, bus.issue_valid, bus.issue_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.issue_valid !== 1'b0 || bus.issue_active !== 1'b0 || bus.issue_id !== 3'd0 ||
        bus.issue_data_addr !== 3'd0) begin
      fails++; $display("FAIL areset_slot: got valid=%0b act=%0b id=%0d addr=%0d, required 0/0/0/0",
                        bus.issue_valid, bus.issue_active, bus.issue_id, bus.issue_data_addr);
    end
    tests++;
    if (bus.inflight_cnt !== 4'd0 || bus.idle !== 1'b1 || bus.issue_count !== 32'd0 ||
        bus.stall_count !== 32'd0) begin
      fails++; $display("FAIL areset_status: got cnt=%0d idle=%0b ic=%0d sc=%0d, required 0/1/0/0",
                        bus.inflight_cnt, bus.idle, bus.issue_count, bus.stall_count);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.idle !== 1'b1 || bus.issue_valid !== 1'b0) begin
      fails++; $display("FAIL areset_release: got idle=%0b valid=%0b, required 1/0", bus.idle, bus.issue_valid);
    end
    retire(0, 1'b0);
    tick();
    clear_inputs();
    tests++;
    if (bus.retire_err !== 1'b1) begin
      fails++; $display("FAIL areset_retire_err: got %0b, required 1", bus.retire_err);
    end
    tick();
    tests++;
    if (bus.retire_err !== 1'b0 || bus.idle !== 1'b1) begin
      fails++; $display("FAIL areset_after: got rerr=%0b idle=%0b, required 0/1", bus.retire_err, bus.idle);
    end
  endtask

  initial begin
    clear_inputs();
    bus.issue_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_first_issue();
    test_round_robin();
    test_stall();
    test_errors();
    test_same_cycle();
    test_async_reset();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
